sram_cache_controller: RTL
==========================

// Module: sram_cache_controller
// PURPOSE
// - Direct-mapped, write-through, no-write-allocate, one-word-line cache between MEM stage and SRAM_Controller.
// - Read hits return in the request cycle.
// - Read misses, and all writes, are sequenced onto the SRAM controller's MEM_R_EN/MEM_W_EN interface.
// - Stalls the pipeline through ready. Sits in the MEM stage, in front of SRAM_Controller.
// PARAMETERS
// - INDEX_BITS  6  log2 of line count (64 lines); index = address[INDEX_BITS+1:2], tag = address[31:INDEX_BITS+2]
// PORTS
// - clk          in   1   system clock, all state on posedge
// - rst          in   1   synchronous, active-high reset
// - MEM_R_EN     in   1   pipeline read request, held until ready
// - MEM_W_EN     in   1   pipeline write request, held until ready; wins if both high
// - address      in   32  byte address; bits [1:0] ignored
// - writeData    in   32  store data
// - readData     out  32  load data, valid when ready=1 on a read
// - ready        out  1   1 = access complete / no access; 0 = stall
// - sram_r_en    out  1   to SRAM_Controller MEM_R_EN
// - sram_w_en    out  1   to SRAM_Controller MEM_W_EN
// - sram_address out  32  to SRAM_Controller address (latched request address)
// - sram_wdata   out  32  to SRAM_Controller writeData (latched writeData)
// - sram_rdata   in   32  from SRAM_Controller readData
// - sram_ready   in   1   from SRAM_Controller ready; sampled only in RD_MISS/WRITE
// - hit_count    out  32  read-hit counter (present only with CACHE_STATS_EN)
// - miss_count   out  32  read-miss counter (present only with CACHE_STATS_EN)
// BEHAVIOUR
// - Storage: data[2^INDEX_BITS] x32, tag[..] x(30-INDEX_BITS), valid[..] x1.
//   hit = valid[idx] && tag[idx]==address tag.
// - Reset: state=IDLE, all valid=0, latched addr/data=0, counters=0.
//   While rst=1: ready=0, sram_r_en=sram_w_en=0.
// - FSM states IDLE, RD_MISS, WRITE:
//   - IDLE, no request: ready=1, readData=0.
//   - IDLE, MEM_W_EN=1: latch address/writeData; next=WRITE; ready=0.
//   - IDLE, MEM_R_EN=1 and hit: ready=1 same cycle, readData=data[idx] (combinational); stay IDLE.
//   - IDLE, MEM_R_EN=1 and miss: latch address; next=RD_MISS; ready=0.
//   - RD_MISS: sram_r_en=1. On sram_ready=1: write data/tag/valid[idx] from sram_rdata, ready=1,
//     readData=sram_rdata (forwarded same cycle), next=IDLE.
//   - WRITE: sram_w_en=1. On sram_ready=1: ready=1; if the line hits on the latched address,
//     update data[idx] (tag/valid unchanged); on miss no allocation; next=IDLE.
// - sram_r_en/sram_w_en are decoded from state only (glitch-free, never both high).
//   They drop in the cycle after sram_ready, so SRAM_Controller's counter returns to 0.
// - Latency with current SRAM_Controller (ready at its counter==5):
//   request cycle 0 -> state change at cycle 1 -> ready at cycle 6. Read hit: 0 extra cycles.
// - Back-to-back: a new request may be accepted in the IDLE cycle directly after completion.
// - Requester changing address mid-access is ignored; latched values are used.
// - Reset mid-access: aborts at the next edge (IDLE, enables 0, all lines invalid). The SRAM write may be partial.
// CONFIGURATION
// - CACHE_STATS_EN defined:
//   - hit_count +1 on each IDLE read hit.
//   - miss_count +1 on each RD_MISS completion.
//   - Both saturate at 32'hFFFFFFFF and are cleared by rst.
// - CACHE_STATS_EN undefined: the counter ports and registers do not exist; behaviour is otherwise identical.
// TESTING (SRAM model: ready 5 cycles after enable rises; INDEX_BITS=6)
// - After rst, read 0x400 (SRAM holds 0xDEADBEEF):
//   - sram_r_en high cycles 1-6, ready=1 and readData=0xDEADBEEF at cycle 6.
//   - Repeat read: ready=1 same cycle, sram_r_en stays 0.
// - Write 0x404 <- 0x12345678 (line invalid): sram_w_en high until sram_ready, ready=1 then.
//   A following read of 0x404 misses (no allocate).
// - Read 0x400, then write 0x400 <- 0xCAFEF00D: SRAM written.
//   A following read of 0x400 hits in 0 cycles with 0xCAFEF00D.
// - Conflict: read 0x400, read 0x500 (same index, new tag) misses and replaces the line. Re-read of 0x400 misses.
// - rst pulsed in cycle 3 of a read miss: next cycle state IDLE, sram_r_en=0, ready=1. Re-read of 0x400 misses.
// - MEM_R_EN=MEM_W_EN=1 in the same cycle: WRITE path taken, sram_r_en never asserts.
// - CACHE_STATS_EN: run the first test -> hit_count=1, miss_count=1. After rst, both read 0.

Source files
------------

// File: rtl/sram_cache_controller.sv
// rtl/sram_cache_controller.sv - direct-mapped write-through one-word-line cache in front of SRAM_Controller
// Optional read hit/miss counters are enabled with `define CACHE_STATS_EN.
module sram_cache_controller #(
   parameter int INDEX_BITS = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        MEM_R_EN,
   input  logic        MEM_W_EN,
   input  logic [31:0] address,
   input  logic [31:0] writeData,
   output logic [31:0] readData,
   output logic        ready,
   output logic        sram_r_en,
   output logic        sram_w_en,
   output logic [31:0] sram_address,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata,
   input  logic        sram_ready
`ifdef CACHE_STATS_EN
   ,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
`endif
);

   localparam int LINES = 1 << INDEX_BITS;
   localparam int TAG_W = 30 - INDEX_BITS;

   typedef enum logic [1:0] {S_IDLE, S_RD_MISS, S_WRITE} state_t;

   state_t              r_state;
   logic [31:0]         r_data [LINES];
   logic [TAG_W-1:0]    r_tag  [LINES];
   logic [LINES-1:0]    r_valid;
   logic [31:0]         r_addr;
   logic [31:0]         r_wdata;
   logic                r_sram_r_en;
   logic                r_sram_w_en;

   logic [INDEX_BITS-1:0] w_req_idx;
   logic [TAG_W-1:0]      w_req_tag;
   logic [INDEX_BITS-1:0] w_lat_idx;
   logic [TAG_W-1:0]      w_lat_tag;
   logic                  w_req_hit;
   logic                  w_lat_hit;
   logic                  w_rd_hit;
   logic                  w_rd_done;
   logic                  w_wr_done;

   assign w_req_idx = address[INDEX_BITS+1:2];
   assign w_req_tag = address[31:INDEX_BITS+2];
   assign w_lat_idx = r_addr[INDEX_BITS+1:2];
   assign w_lat_tag = r_addr[31:INDEX_BITS+2];
   assign w_req_hit = r_valid[w_req_idx] && (r_tag[w_req_idx] == w_req_tag);
   assign w_lat_hit = r_valid[w_lat_idx] && (r_tag[w_lat_idx] == w_lat_tag);
   assign w_rd_hit  = !rst && (r_state == S_IDLE) && MEM_R_EN && !MEM_W_EN && w_req_hit;
   assign w_rd_done = (r_state == S_RD_MISS) && sram_ready;
   assign w_wr_done = (r_state == S_WRITE) && sram_ready;

   // Enables are registered per state; rst masks them so the SRAM sees nothing during reset.
   assign sram_r_en    = r_sram_r_en && !rst;
   assign sram_w_en    = r_sram_w_en && !rst;
   assign sram_address = r_addr;
   assign sram_wdata   = r_wdata;

   always_comb begin
      ready    = 1'b0;
      readData = 32'h0;
      if (!rst) begin
         case (r_state)
            S_IDLE: begin
               if (MEM_W_EN) begin
                  ready = 1'b0;
               end else if (MEM_R_EN) begin
                  ready    = w_rd_hit;
                  readData = w_rd_hit ? r_data[w_req_idx] : 32'h0;
               end else begin
                  ready = 1'b1;
               end
            end
            S_RD_MISS: begin
               ready    = sram_ready;
               readData = sram_ready ? sram_rdata : 32'h0;
            end
            S_WRITE: ready = sram_ready;
            default: ready = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_valid     <= '0;
         r_addr      <= 32'h0;
         r_wdata     <= 32'h0;
         r_sram_r_en <= 1'b0;
         r_sram_w_en <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (MEM_W_EN) begin
                  r_addr      <= address;
                  r_wdata     <= writeData;
                  r_state     <= S_WRITE;
                  r_sram_w_en <= 1'b1;
               end else if (MEM_R_EN && !w_req_hit) begin
                  r_addr      <= address;
                  r_state     <= S_RD_MISS;
                  r_sram_r_en <= 1'b1;
               end
            end
            S_RD_MISS: begin
               if (sram_ready) begin
                  r_valid[w_lat_idx] <= 1'b1;
                  r_state            <= S_IDLE;
                  r_sram_r_en        <= 1'b0;
               end
            end
            S_WRITE: begin
               if (sram_ready) begin
                  r_state     <= S_IDLE;
                  r_sram_w_en <= 1'b0;
               end
            end
            default: begin
               r_state     <= S_IDLE;
               r_sram_r_en <= 1'b0;
               r_sram_w_en <= 1'b0;
            end
         endcase
      end
   end

   // Data/tag arrays carry no reset; valid bits alone decide whether a line is usable.
   always_ff @(posedge clk) begin
      if (!rst && w_rd_done) begin
         r_data[w_lat_idx] <= sram_rdata;
         r_tag[w_lat_idx]  <= w_lat_tag;
      end else if (!rst && w_wr_done && w_lat_hit) begin
         r_data[w_lat_idx] <= r_wdata;
      end
   end

`ifdef CACHE_STATS_EN
   logic [31:0] r_hit_count;
   logic [31:0] r_miss_count;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_hit_count  <= 32'h0;
         r_miss_count <= 32'h0;
      end else begin
         if (w_rd_hit && (r_hit_count != 32'hFFFF_FFFF))
            r_hit_count <= r_hit_count + 32'h1;
         if (w_rd_done && (r_miss_count != 32'hFFFF_FFFF))
            r_miss_count <= r_miss_count + 32'h1;
      end
   end

   assign hit_count  = r_hit_count;
   assign miss_count = r_miss_count;
`endif

endmodule
